keycode_decoder: RTL and testbench
==================================

# keycode_decoder

Receiving end of the Nios keycode PIO: turns the raw two-slot USB HID keycode word into frame-synchronous, one-cycle game command pulses with optional hold-to-repeat. It sits between the nios_system `keycode_export` output and gamestate, is clocked by `Clk`, and uses `VGA_VS` as its frame reference. Cursor movement therefore advances at most once per frame regardless of how fast software updates the PIO.

## Interface
- `REPEAT_DELAY`, 12: frames from the initial press pulse to the first repeat pulse; legal range 1..63.
- `REPEAT_RATE`, 4: frames between subsequent repeat pulses; legal range 1..63.
- `Clk` input 1: 50 MHz system clock. One clock only.
- `Reset` input 1: synchronous, active-high reset.
- `frame_clk` input 1: VGA vertical sync (`VGA_VS`), treated as asynchronous.
- `keycode` input 16: `[7:0]` is key slot 0 and `[15:8]` is key slot 1; HID usage codes; 0x00 means empty.
- `frame_tick` output 1: one-cycle pulse on each synchronized `frame_clk` rising edge.
- `cmd_up`, `cmd_down`, `cmd_left`, `cmd_right` outputs 1 each: one-cycle move pulses.
- `cmd_swap` output 1: one-cycle pulse on press only; never repeats.
- `raise_held` output 1: level output; key R is held as of the last frame tick.

## Operation
- **Key map (HID codes):** W=0x1A up, S=0x16 down, A=0x04 left, D=0x07 right, Space=0x2C swap, R=0x15 raise.
- **Presence:** `present[k]` is true when either slot equals the code for key k. The same code in both slots counts once.
- **Sampling:** `keycode` is sampled only in the cycle `frame_tick` is high. Changes between ticks are invisible.
- **Conflicting pairs:** if up and down are both present, both are treated as absent for that tick. The same rule applies to left and right.
- **Per-key FSM** for the four direction keys, each with a 6-bit frame counter `cnt`:
  - IDLE: on a tick with the key present, pulse the command, set `cnt=0`, go to DELAY. Otherwise stay in IDLE.
  - DELAY: on a tick with the key absent, go to IDLE with no pulse. With the key present, increment `cnt`. When `cnt` reaches `REPEAT_DELAY`, pulse, set `cnt=0`, go to REPEAT.
  - REPEAT: on a tick with the key absent, go to IDLE. With the key present, increment `cnt`. When `cnt` reaches `REPEAT_RATE`, pulse and set `cnt=0`.
  - Counters advance only on ticks and never wrap, because the parameter ceiling (63) fits in 6 bits.
- **Swap FSM (IDLE/HELD):** pulse on the IDLE→HELD transition. Return to IDLE on a tick with the key absent.
- **Raise:** `raise_held` is registered from `present[R]` on each tick.
- **frame_clk synchronizer:** two-flop synchronizer `vs_s1`, `vs_s2`, plus delay flop `vs_s3`; `frame_tick = vs_s2 & ~vs_s3`.
- **Reset behaviour:**
  - All FSMs go to IDLE, counters to 0, and all outputs to 0.
  - `vs_s1`, `vs_s2` and `vs_s3` reset to 1, so a `frame_clk` already high at reset release does not produce a spurious tick.
  - A key held across reset release is treated as a new press at the first genuine tick.
- **Reset mid-repeat:** abandons the sequence immediately; no pulse is emitted in the reset cycle.

## Timing
- `frame_tick` goes high in the cycle after the second Clk edge that samples `frame_clk` high, and lasts one cycle.
- Command pulses and `raise_held` update on the Clk edge ending the tick cycle, so they are high for exactly one cycle, one cycle after `frame_tick`.
- End-to-end latency: the 3rd Clk edge after `frame_clk` rises.
- A held direction key produces pulses on tick 0, tick `REPEAT_DELAY`, then every `REPEAT_RATE` ticks after that.
- At most one pulse per command per frame. Different commands may pulse in the same cycle (for example `cmd_up` and `cmd_swap`).
- A release and re-press within the same tick interval is invisible to the block.

## Configuration
- Macro: `KEYCODE_DECODER_AUTO_REPEAT_EN`.
- **Defined:** the direction FSMs are built as described above (IDLE/DELAY/REPEAT with counters).
- **Undefined:** the direction FSMs reduce to IDLE/HELD like swap. A pulse is produced on press only, the counters and the `REPEAT_*` parameters are unused, and there is no repeat while held.
- Swap, raise, `frame_tick` and conflict handling are identical in both builds.

## Test plan
- **Single press:** `keycode=0x001A` held for 1 tick, then 0x0000 → one `cmd_up` pulse, one cycle wide, 1 cycle after `frame_tick`; no other outputs.
- **Auto-repeat:** `keycode=0x0700` held for 30 ticks, defaults, macro defined → `cmd_right` on ticks 0, 12, 16, 20, 24, 28 (6 pulses). With the macro undefined → 1 pulse.
- **Conflict:** `keycode=0x1604` (S in slot 1, A in slot 0) → `cmd_down` and `cmd_left` pulse together. Then `keycode=0x0704` (D and A) → no left or right pulses while both are held.
- **Swap and raise:** `keycode=0x2C15` held for 5 ticks → one `cmd_swap` pulse; `raise_held`=1 from tick 0 through tick 4, and 0 after the first tick following release.
- **Reset edge cases:**
  - Assert `Reset` while `frame_clk`=1, release with `frame_clk` still 1 → no `frame_tick` until the next low→high transition.
  - Assert `Reset` mid-REPEAT on `cmd_left` → all outputs 0. With A still held, `cmd_left` pulses again on the first post-reset tick.
- **Duplicate slots:** `keycode=0x1A1A` → behaviour identical to 0x001A (single pulse per tick schedule).

Source files
------------

// File: rtl/keycode_decoder.sv
// keycode_decoder: turns the two-slot USB HID keycode word from the Nios PIO
// into frame-synchronous, one-cycle game command pulses.
// Build option: define KEYCODE_DECODER_AUTO_REPEAT_EN to give the four
// direction keys hold-to-repeat (IDLE/DELAY/REPEAT with frame counters);
// without it they pulse on press only (IDLE/HELD, like swap).
module keycode_decoder #(
   parameter int REPEAT_DELAY = 12,  // frames from press pulse to first repeat (1..63)
   parameter int REPEAT_RATE  = 4    // frames between later repeats (1..63)
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [15:0] keycode,
   output logic        frame_tick,
   output logic        cmd_up,
   output logic        cmd_down,
   output logic        cmd_left,
   output logic        cmd_right,
   output logic        cmd_swap,
   output logic        raise_held
);

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_R     = 8'h15;

   // Direction slots: 0 up, 1 down, 2 left, 3 right.
   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HELD   = 2'd1,
      S_DELAY  = 2'd2,
      S_REPEAT = 2'd3
   } key_state_e;

   // Out-of-range repeat parameters would overflow the 6-bit frame counters.
   if ((REPEAT_DELAY < 1) || (REPEAT_DELAY > 63)) begin : g_bad_repeat_delay
      $error("keycode_decoder: REPEAT_DELAY must be in 1..63");
   end
   if ((REPEAT_RATE < 1) || (REPEAT_RATE > 63)) begin : g_bad_repeat_rate
      $error("keycode_decoder: REPEAT_RATE must be in 1..63");
   end

`ifdef KEYCODE_DECODER_AUTO_REPEAT_EN
   localparam logic [5:0] DELAY_CNT = 6'(REPEAT_DELAY);
   localparam logic [5:0] RATE_CNT  = 6'(REPEAT_RATE);
   logic [5:0] cnt_q [4];
   logic [5:0] cnt_d [4];
`endif

   logic       vs_s1_q, vs_s2_q, vs_s3_q;
   key_state_e dir_state_q [4];
   key_state_e dir_state_d [4];
   logic [3:0] dir_pulse_q, dir_pulse_d;
   key_state_e swap_state_q, swap_state_d;
   logic       swap_pulse_q, swap_pulse_d;
   logic       raise_q, raise_d;

   logic [3:0] dir_raw, dir_eff;
   logic       present_swap, present_raise;

   // A code counts as present if either slot carries it; duplicates count once.
   function automatic logic key_present(input logic [15:0] kc, input logic [7:0] code);
      return (kc[7:0] == code) || (kc[15:8] == code);
   endfunction

   // frame_clk synchronizer; flops come out of reset high so a frame_clk that
   // is already high at release is not mistaken for a rising edge.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      if (Reset) begin
         vs_s1_q <= 1'b1;
         vs_s2_q <= 1'b1;
         vs_s3_q <= 1'b1;
      end else begin
         vs_s1_q <= frame_clk;
         vs_s2_q <= vs_s1_q;
         vs_s3_q <= vs_s2_q;
      end
   end

   assign frame_tick = vs_s2_q & ~vs_s3_q;

   // Key presence with opposing-direction pairs cancelling each other out.
   always_comb begin
      dir_raw[DIR_UP]    = key_present(keycode, KEY_W);
      dir_raw[DIR_DOWN]  = key_present(keycode, KEY_S);
      dir_raw[DIR_LEFT]  = key_present(keycode, KEY_A);
      dir_raw[DIR_RIGHT] = key_present(keycode, KEY_D);
      dir_eff = dir_raw;
      if (dir_raw[DIR_UP] && dir_raw[DIR_DOWN]) begin
         dir_eff[DIR_UP]   = 1'b0;
         dir_eff[DIR_DOWN] = 1'b0;
      end
      if (dir_raw[DIR_LEFT] && dir_raw[DIR_RIGHT]) begin
         dir_eff[DIR_LEFT]  = 1'b0;
         dir_eff[DIR_RIGHT] = 1'b0;
      end
      present_swap  = key_present(keycode, KEY_SPACE);
      present_raise = key_present(keycode, KEY_R);
   end

   // Direction FSM next state and pulses; everything advances only on a tick.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      dir_pulse_d = '0;
      for (int k = 0; k < 4; k++) begin
         dir_state_d[k] = dir_state_q[k];
`ifdef KEYCODE_DECODER_AUTO_REPEAT_EN
         cnt_d[k] = cnt_q[k];
         if (frame_tick) begin
            case (dir_state_q[k])
               S_IDLE: begin
                  if (dir_eff[k]) begin
                     dir_pulse_d[k] = 1'b1;
                     cnt_d[k]       = '0;
                     dir_state_d[k] = S_DELAY;
                  end
               end
               S_DELAY: begin
                  if (!dir_eff[k]) begin
                     dir_state_d[k] = S_IDLE;
                  end else begin
                     cnt_d[k] = cnt_q[k] + 6'd1;
                     if (cnt_d[k] == DELAY_CNT) begin
                        dir_pulse_d[k] = 1'b1;
                        cnt_d[k]       = '0;
                        dir_state_d[k] = S_REPEAT;
                     end
                  end
               end
               S_REPEAT: begin
                  if (!dir_eff[k]) begin
                     dir_state_d[k] = S_IDLE;
                  end else begin
                     cnt_d[k] = cnt_q[k] + 6'd1;
                     if (cnt_d[k] == RATE_CNT) begin
                        dir_pulse_d[k] = 1'b1;
                        cnt_d[k]       = '0;
                     end
                  end
               end
               default: dir_state_d[k] = S_IDLE;
            endcase
         end
`else
         if (frame_tick) begin
            case (dir_state_q[k])
               S_IDLE: begin
                  if (dir_eff[k]) begin
                     dir_pulse_d[k] = 1'b1;
                     dir_state_d[k] = S_HELD;
                  end
               end
               S_HELD: begin
                  if (!dir_eff[k]) dir_state_d[k] = S_IDLE;
               end
               default: dir_state_d[k] = S_IDLE;
            endcase
         end
`endif
      end
   end

   // Swap press-only FSM and the raise level, both updated on ticks.
   always_comb begin
      swap_state_d = swap_state_q;
      swap_pulse_d = 1'b0;
      raise_d      = raise_q;
      if (frame_tick) begin
         raise_d = present_raise;
         case (swap_state_q)
            S_IDLE: begin
               if (present_swap) begin
                  swap_pulse_d = 1'b1;
                  swap_state_d = S_HELD;
               end
            end
            S_HELD: begin
               if (!present_swap) swap_state_d = S_IDLE;
            end
            default: swap_state_d = S_IDLE;
         endcase
      end
   end

   // State, counter and output registers; reset abandons any repeat at once.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         // NOTE: the per-key state arrays are tiny, so they are reset like any
         // other register rather than treated as an unreset memory.
         for (int k = 0; k < 4; k++) begin
            dir_state_q[k] <= S_IDLE;
`ifdef KEYCODE_DECODER_AUTO_REPEAT_EN
            cnt_q[k]       <= '0;
`endif
         end
         dir_pulse_q  <= '0;
         swap_state_q <= S_IDLE;
         swap_pulse_q <= 1'b0;
         raise_q      <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            dir_state_q[k] <= dir_state_d[k];
`ifdef KEYCODE_DECODER_AUTO_REPEAT_EN
            cnt_q[k]       <= cnt_d[k];
`endif
         end
         dir_pulse_q  <= dir_pulse_d;
         swap_state_q <= swap_state_d;
         swap_pulse_q <= swap_pulse_d;
         raise_q      <= raise_d;
      end
   end

   assign cmd_up     = dir_pulse_q[DIR_UP];
   assign cmd_down   = dir_pulse_q[DIR_DOWN];
   assign cmd_left   = dir_pulse_q[DIR_LEFT];
   assign cmd_right  = dir_pulse_q[DIR_RIGHT];
   assign cmd_swap   = swap_pulse_q;
   assign raise_held = raise_q;

endmodule

// File: tb/tb_keycode_decoder.sv
// Self-checking bench for keycode_decoder. A frame-level model predicts every
// output on every clock; directed scenarios add literal pulse-count checks.
// Honours KEYCODE_DECODER_AUTO_REPEAT_EN the same way the design does.
`timescale 1ns/1ps
module tb_keycode_decoder;

   localparam int D = 12;
   localparam int R = 4;
`ifdef KEYCODE_DECODER_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic [15:0] keycode;
   logic        frame_tick, cmd_up, cmd_down, cmd_left, cmd_right, cmd_swap, raise_held;

   int checks   = 0;
   int failures = 0;

   keycode_decoder #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .keycode    (keycode),
      .frame_tick (frame_tick),
      .cmd_up     (cmd_up),
      .cmd_down   (cmd_down),
      .cmd_left   (cmd_left),
      .cmd_right  (cmd_right),
      .cmd_swap   (cmd_swap),
      .raise_held (raise_held)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit has(input logic [15:0] kc, input logic [7:0] code);
      return (kc[7:0] == code) || (kc[15:8] == code);
   endfunction

   // ---------------- frame-level model ----------------
   // held_n[k] = how many ticks key k has been continuously held before this
   // one (-1 when released). Pulse rule: first tick, then tick D, D+R, D+2R...
   bit       m_valid = 1'b0;
   bit       m_tick  = 1'b0;
   bit       fc_prev1 = 1'b1, fc_prev2 = 1'b1;
   int       held_n [4];
   bit       swap_down = 1'b0;
   bit [3:0] e_dir = '0;
   bit       e_swap = 1'b0, e_raise = 1'b0;

   always @(posedge Clk) begin
      bit [3:0] raw, eff;
      m_valid = 1'b1;
      if (Reset) begin
         e_dir = '0; e_swap = 1'b0; e_raise = 1'b0; m_tick = 1'b0;
         fc_prev1 = 1'b1; fc_prev2 = 1'b1;
         held_n = '{default: -1};
         swap_down = 1'b0;
      end else begin
         e_dir  = '0;
         e_swap = 1'b0;
         if (m_tick) begin
            raw = {has(keycode, 8'h07), has(keycode, 8'h04), has(keycode, 8'h16), has(keycode, 8'h1A)};
            eff = raw;
            if (raw[0] && raw[1]) eff[1:0] = 2'b00;
            if (raw[2] && raw[3]) eff[3:2] = 2'b00;
            for (int k = 0; k < 4; k++) begin
               if (eff[k]) begin
                  held_n[k]++;
                  if (held_n[k] == 0 || (AUTO && held_n[k] >= D && (held_n[k] - D) % R == 0))
                     e_dir[k] = 1'b1;
               end else begin
                  held_n[k] = -1;
               end
            end
            e_swap    = has(keycode, 8'h2C) && !swap_down;
            swap_down = has(keycode, 8'h2C);
            e_raise   = has(keycode, 8'h15);
         end
         // A frame_clk rise seen at one edge is reported after the next edge.
         m_tick   = fc_prev1 && !fc_prev2;
         fc_prev2 = fc_prev1;
         fc_prev1 = frame_clk;
      end
   end

   // ---------------- per-cycle compare and pulse counting ----------------
   int n_dir [4];
   int mn_dir [4];
   int n_swap = 0, mn_swap = 0, n_tick = 0, n_down_left = 0;

   always @(negedge Clk) begin
      if (m_valid) begin
         check("frame_tick", frame_tick, m_tick);
         check("cmd_up",     cmd_up,     e_dir[0]);
         check("cmd_down",   cmd_down,   e_dir[1]);
         check("cmd_left",   cmd_left,   e_dir[2]);
         check("cmd_right",  cmd_right,  e_dir[3]);
         check("cmd_swap",   cmd_swap,   e_swap);
         check("raise_held", raise_held, e_raise);
         if (cmd_up)    n_dir[0]++;
         if (cmd_down)  n_dir[1]++;
         if (cmd_left)  n_dir[2]++;
         if (cmd_right) n_dir[3]++;
         if (cmd_swap)  n_swap++;
         if (frame_tick) n_tick++;
         if (cmd_down && cmd_left) n_down_left++;
         for (int k = 0; k < 4; k++) if (e_dir[k]) mn_dir[k]++;
         if (e_swap) mn_swap++;
      end
   end

   task automatic clear_counts();
      for (int k = 0; k < 4; k++) begin
         n_dir[k]  = 0;
         mn_dir[k] = 0;
      end
      n_swap = 0; mn_swap = 0; n_tick = 0; n_down_left = 0;
   endtask

   // One frame_clk period: 4 clocks high, 4 clocks low -> exactly one tick.
   task automatic do_frame();
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {frame_tick, cmd_up, cmd_down, cmd_left, cmd_right, cmd_swap, raise_held}, 0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      clear_counts();
      Reset = 1'b1; frame_clk = 1'b0; keycode = 16'h0000;
      repeat (4) @(negedge Clk);
      check_all_zero("reset");
      Reset = 1'b0;
      repeat (4) @(negedge Clk);

      // Single press of W for one tick.
      clear_counts();
      keycode = 16'h001A; do_frame();
      keycode = 16'h0000; do_frame(); do_frame();
      check("single_up", n_dir[0], 1);
      check("single_model_up", mn_dir[0], 1);
      check("single_others", n_dir[1] + n_dir[2] + n_dir[3] + n_swap, 0);
      check("single_ticks", n_tick, 3);

      // Same code in both slots behaves like one slot.
      clear_counts();
      keycode = 16'h1A1A; do_frame();
      keycode = 16'h0000; do_frame();
      check("dup_up", n_dir[0], 1);

      // D held in slot 1 for 30 ticks.
      clear_counts();
      keycode = 16'h0700;
      repeat (30) do_frame();
      keycode = 16'h0000; do_frame();
      check("repeat_right", n_dir[3], AUTO ? 6 : 1);
      check("repeat_model_right", mn_dir[3], AUTO ? 6 : 1);

      // S + A pulse together; then A + D cancel.
      clear_counts();
      keycode = 16'h1604; do_frame();
      check("conf_down", n_dir[1], 1);
      check("conf_left", n_dir[2], 1);
      check("conf_same_cycle", n_down_left, 1);
      clear_counts();
      keycode = 16'h0704;
      repeat (3) do_frame();
      check("conf_lr_none", n_dir[2] + n_dir[3], 0);
      keycode = 16'h0000; do_frame();

      // Space + R held for 5 ticks.
      clear_counts();
      keycode = 16'h2C15; do_frame();
      check("raise_first", raise_held, 1);
      repeat (4) do_frame();
      check("swap_once", n_swap, 1);
      check("swap_model_once", mn_swap, 1);
      check("raise_held5", raise_held, 1);
      keycode = 16'h0000; do_frame();
      check("raise_released", raise_held, 0);

      // Reset applied and released while frame_clk stays high.
      frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      clear_counts();
      repeat (8) @(negedge Clk);
      check("rst_high_no_tick", n_tick, 0);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      do_frame();
      check("rst_high_one_tick", n_tick, 1);

      // Reset mid-repeat on A, landing on the tick that would repeat.
      clear_counts();
      keycode = 16'h0004;
      repeat (16) do_frame();
      check("mid_left_before", n_dir[2], AUTO ? 2 : 1);
      frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      check_all_zero("mid_reset");
      check("mid_left_suppressed", n_dir[2], AUTO ? 2 : 1);
      Reset = 1'b0;
      clear_counts();
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      do_frame();
      check("mid_left_repress", n_dir[2], 1);
      check("mid_model_repress", mn_dir[2], 1);
      keycode = 16'h0000; do_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
